// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the round-robin bit-serial 1101 scanner.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: sequencer state encoding, detector state encoding, pattern constant.
package seq_scan_pkg;

  // Sequencer states: one job in flight, walked IDLE -> CLR -> SHIFT -> DRAIN -> RESP.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } scan_state_t;

  // Detector states are named by the longest pattern prefix seen so far.
  typedef enum logic [1:0] {
    DET_S0   = 2'd0,
    DET_S1   = 2'd1,
    DET_S11  = 2'd2,
    DET_S110 = 2'd3
  } det_state_t;

  localparam logic [3:0] PATTERN     = 4'b1101;
  localparam int         PATTERN_LEN = 4;

endpackage

// File: rtl/det_1101_core.sv
// Overlapping Mealy detector for the serial pattern 1101.
// Latency: y is a registered pulse in the cycle after the bit that completes the pattern.
// Backpressure: none; consumes one bit per cycle unconditionally.
// Ports: clk, rst (synchronous, active-high), din (serial bit), y (match pulse).
module det_1101_core
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic y
);

  det_state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DET_S0;
      y     <= 1'b0;
    end else begin
      y <= 1'b0;
      case (state)
        DET_S0:  state <= din ? DET_S1  : DET_S0;
        DET_S1:  state <= din ? DET_S11 : DET_S0;
        // A run of 1s keeps "11" as the live prefix.
        DET_S11: state <= din ? DET_S11 : DET_S110;
        DET_S110: begin
          if (din == PATTERN[0]) begin
            // Match; the closing 1 is reused as the first 1 of the next pattern.
            y     <= 1'b1;
            state <= DET_S1;
          end else begin
            state <= DET_S0;
          end
        end
        default: state <= DET_S0;
      endcase
    end
  end

endmodule

// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter that feeds requester words MSB-first through one shared 1101 detector.
// Latency: rsp_valid rises WIDTH+2 cycles after the accept edge; next accept one cycle after rsp handshake.
// Backpressure: req_ready only in IDLE (one job in flight); RESP holds outputs until rsp_ready.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake, req_ready one-hot
//   req_data                 packed words, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready      result handshake
//   rsp_id/rsp_count/rsp_hit scanned requester, saturating match count, count != 0
module seq_scan_arbiter
  import seq_scan_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [CNTW-1:0]       rsp_count,
  output logic                  rsp_hit
);

  localparam int              BCW      = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  // Returns {found, index}: first valid requester at or above ptr, wrapping.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0]   res;
    logic [IDW-1:0] cand;
    logic           found;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!found && v[cand]) begin
        found = 1'b1;
        res   = {1'b1, cand};
      end
    end
    return res;
  endfunction

  scan_state_t       state;
  logic [IDW-1:0]    rr_ptr;
  logic [WIDTH-1:0]  sreg;
  logic [BCW-1:0]    bitcnt;

  logic [IDW:0]      pick;
  logic              grant_vld;
  logic [IDW-1:0]    win;
  logic [IDW-1:0]    win_next;

  logic              det_rst;
  logic              det_din;
  logic              det_y;
  logic              cnt_inc;

  assign pick      = rr_pick(req_valid, rr_ptr);
  assign grant_vld = pick[IDW];
  assign win       = pick[IDW-1:0];
  assign win_next  = IDW'((int'(win) + 1) % NREQ);

  // The grant is re-evaluated every IDLE cycle, so a requester that drops
  // req_valid before being accepted simply loses its turn.
  always_comb begin
    req_ready = '0;
    if (!rst && (state == ST_IDLE) && grant_vld) begin
      req_ready[win] = 1'b1;
    end
  end

  // Detector is cleared during CLR so a match can never span two words.
  assign det_rst = rst || (state == ST_CLR);
  assign det_din = (state == ST_SHIFT) && sreg[WIDTH-1];

  // y lags its bit by one cycle: the first SHIFT cycle sees the CLR reset
  // value, and DRAIN catches the pulse belonging to the last bit.
  assign cnt_inc = det_y && ((state == ST_SHIFT) || (state == ST_DRAIN));

  det_1101_core u_det (
    .clk (clk),
    .rst (det_rst),
    .din (det_din),
    .y   (det_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      sreg      <= '0;
      bitcnt    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_count <= '0;
      rsp_hit   <= 1'b0;
    end else begin
      if (cnt_inc) begin
        rsp_hit <= 1'b1;
        if (rsp_count != CNT_MAX) begin
          rsp_count <= rsp_count + CNTW'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            sreg      <= req_data[int'(win)*WIDTH +: WIDTH];
            rsp_id    <= win;
            rr_ptr    <= win_next;
            rsp_count <= '0;
            rsp_hit   <= 1'b0;
            bitcnt    <= '0;
            state     <= ST_CLR;
          end
        end

        ST_CLR: begin
          state <= ST_SHIFT;
        end

        ST_SHIFT: begin
          sreg   <= {sreg[WIDTH-2:0], 1'b0};
          bitcnt <= bitcnt + BCW'(1);
          if (bitcnt == LAST_BIT) begin
            bitcnt <= '0;
            state  <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Self-checking bench for seq_scan_arbiter: directed vector table, hand-written
// backpressure / mid-job reset sequences, then randomized jobs against a model.
module tb_seq_scan_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int CNTW  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [CNTW-1:0]       rsp_count;
  logic                  rsp_hit;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  seq_scan_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .rsp_hit   (rsp_hit)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: count every (overlapping) 4-bit window equal to 1101, saturating.
  function automatic int model_count(input logic [WIDTH-1:0] w);
    int n;
    logic [3:0] win;
    n = 0;
    for (int i = WIDTH-1; i >= 3; i--) begin
      win = w[i -: 4];
      if (win == 4'b1101) n++;
    end
    if (n > (1 << CNTW) - 1) n = (1 << CNTW) - 1;
    return n;
  endfunction

  // Reference: first valid requester at or after ptr, wrapping around.
  function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_id",    rsp_id,    0);
    check("rst rsp_count", rsp_count, 0);
    check("rst rsp_hit",   rsp_hit,   0);
    check("rst req_ready", req_ready, 0);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // Entered and left at posedge+2 with the DUT in IDLE.
  task automatic run_job(input string name, input logic [NREQ-1:0] valid,
                         input logic [NREQ*WIDTH-1:0] data, input int exp_id,
                         input int exp_cnt, input logic exp_hit, input bit hold,
                         input int bp);
    int n;
    int nxt;
    logic [NREQ-1:0] got;
    req_valid = valid;
    req_data  = data;
    rsp_ready = (bp == 0);
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      @(posedge clk); #2; n++;
    end
    if (req_ready == '0) begin
      timeout({name, " grant"});
      return;
    end
    check({name, " req_ready"}, req_ready, NREQ'(1) << exp_id);
    got = req_ready;
    @(posedge clk); #2;
    req_valid = hold ? valid : (valid & ~got);
    check({name, " ready drop"}, req_ready, 0);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #2; n++;
    end
    check({name, " latency"}, n, WIDTH + 2);
    check({name, " rsp_id"},    rsp_id,    exp_id);
    check({name, " rsp_count"}, rsp_count, exp_cnt);
    check({name, " rsp_hit"},   rsp_hit,   exp_hit);
    for (int c = 0; c < bp; c++) begin
      @(posedge clk); #2;
      check({name, " hold"}, {rsp_valid, rsp_id, rsp_count, rsp_hit, req_ready},
            {1'b1, IDW'(exp_id), CNTW'(exp_cnt), exp_hit, NREQ'(0)});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    check({name, " rsp_valid low"}, rsp_valid, 0);
    m_ptr = (exp_id + 1) % NREQ;
    if (req_valid != '0) begin
      nxt = model_pick(req_valid, m_ptr);
      check({name, " next grant"}, req_ready, NREQ'(1) << nxt);
    end
  endtask

  typedef struct {
    logic                  pre_rst;
    logic                  hold;
    logic [NREQ-1:0]       valid;
    logic [NREQ*WIDTH-1:0] data;
    int                    exp_id;
    int                    exp_cnt;
    logic                  exp_hit;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0]       rv;
    logic [NREQ*WIDTH-1:0] rd;
    int                    eid;
    int                    ecnt;

    //          pre_rst hold  valid    data           id cnt hit
    tbl[0]  = '{1'b0, 1'b0, 4'b0001, 32'h0000_00DA, 0, 2, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 4'b0001, 32'h0000_00FF, 0, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'b0010, 32'h0000_6800, 1, 1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 4'b0100, 32'h00DD_0000, 2, 2, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 4'b1000, 32'h0600_0000, 3, 0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'b0001, 32'h0000_0080, 0, 0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'b0101, 32'h005B_00DB, 2, 1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 4'b0101, 32'h005B_00DB, 0, 2, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 4'b1111, 32'hFFDD_68DA, 0, 2, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 4'b1111, 32'hFFDD_68DA, 1, 1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 4'b1111, 32'hFFDD_68DA, 2, 2, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 4'b1111, 32'hFFDD_68DA, 3, 0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 4'b1111, 32'hFFDD_68DA, 0, 2, 1'b1};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].pre_rst) do_reset();
      run_job($sformatf("vec%0d", i), tbl[i].valid, tbl[i].data, tbl[i].exp_id,
              tbl[i].exp_cnt, tbl[i].exp_hit, tbl[i].hold, 0);
    end

    // Backpressure: 20 cycles with rsp_ready low while requester 0 waits.
    run_job("backpressure", 4'b0011, 32'h0000_DBDA, 1, 2, 1'b1, 1'b0, 20);

    // Reset during bit 4 of a job from requester 1.
    req_valid = 4'b0010;
    req_data  = 32'h0000_D000;
    #1;
    check("abort grant", req_ready, 4'b0010);
    @(posedge clk); #2;
    req_valid = 4'b0101;
    req_data  = 32'h00DD_00DA;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort rsp_valid", rsp_valid, 0);
    check("abort req_ready", req_ready, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    m_ptr = 0;
    check("abort cleared", {rsp_valid, rsp_id, rsp_count, rsp_hit}, 0);
    run_job("post reset", 4'b0101, 32'h00DD_00DA, 0, 2, 1'b1, 1'b0, 0);

    // Randomized jobs against the reference model.
    for (int j = 0; j < 40; j++) begin
      rv   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      rd   = $urandom;
      eid  = model_pick(rv, m_ptr);
      ecnt = model_count(rd[eid*WIDTH +: WIDTH]);
      run_job($sformatf("rand%0d", j), rv, rd, eid, ecnt, ecnt != 0,
              bit'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    req_valid = '0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
